// File: rtl/servo_pkg.sv
// Shared definitions for the servo pose sequencer: duty-code width, default limits and FSM states.
package servo_pkg;

    localparam int unsigned DC_W        = 11;
    localparam int unsigned DEF_DC_MIN  = 25;
    localparam int unsigned DEF_DC_MAX  = 125;
    localparam int unsigned DEF_STEP    = 5;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRamp,
        StDwell
    } seq_state_e;

    function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W-1:0] v,
                                                 input logic [DC_W-1:0] lo,
                                                 input logic [DC_W-1:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/servo_joint_ramp.sv
// One servo lane: holds the latched pose target and the current duty code, and slews the
// duty code toward the target by at most STEP per tick.
module servo_joint_ramp
    import servo_pkg::*;
#(
    parameter int unsigned DC_MIN = DEF_DC_MIN,
    parameter int unsigned DC_MAX = DEF_DC_MAX,
    parameter int unsigned STEP   = DEF_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DC_W-1:0] target,
    input  logic            tick,
    input  logic            load_en,
    output logic [DC_W-1:0] dc,
    output logic            at_target
);

    localparam logic signed [DC_W:0] STEP_S = (DC_W + 1)'(STEP);
    localparam logic signed [DC_W:0] LO_S   = (DC_W + 1)'(DC_MIN);
    localparam logic signed [DC_W:0] HI_S   = (DC_W + 1)'(DC_MAX);

    logic [DC_W-1:0]        dc_q, dc_d;
    logic [DC_W-1:0]        target_q;
    logic signed [DC_W:0]   diff;
    logic signed [DC_W:0]   delta;
    logic signed [DC_W:0]   next_s;

    always_comb begin
        diff = $signed({1'b0, target_q}) - $signed({1'b0, dc_q});
        if (diff > STEP_S) begin
            delta = STEP_S;
        end else if (diff < -STEP_S) begin
            delta = -STEP_S;
        end else begin
            delta = diff;
        end
        next_s = $signed({1'b0, dc_q}) + delta;
        // Guard rail: the lane never leaves the legal duty window.
        if (next_s < LO_S) begin
            next_s = LO_S;
        end else if (next_s > HI_S) begin
            next_s = HI_S;
        end
        dc_d = next_s[DC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dc_q     <= DC_W'(DC_MIN);
            target_q <= DC_W'(DC_MIN);
        end else begin
            if (load_en) begin
                target_q <= target;
            end
            if (tick) begin
                dc_q <= dc_d;
            end
        end
    end

    assign dc        = dc_q;
    assign at_target = (dc_q == target_q);

endmodule

// File: rtl/servo_pose_sequencer.sv
// Plays a programmed table of arm poses on N_JOINTS servo lanes: load, ramp, dwell, advance.
module servo_pose_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned N_JOINTS    = 4,
    parameter int unsigned N_POSES     = 8,
    parameter int unsigned DC_MIN      = DEF_DC_MIN,
    parameter int unsigned DC_MAX      = DEF_DC_MAX,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int unsigned TICK_DIV    = 1_000_000,
    parameter int unsigned DWELL_TICKS = 25,
    localparam int unsigned PW = (N_POSES > 1) ? $clog2(N_POSES) : 1,
    localparam int unsigned JW = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [PW-1:0]            last_pose,
    input  logic                     cfg_we,
    input  logic [PW-1:0]            cfg_pose,
    input  logic [JW-1:0]            cfg_joint,
    input  logic [DC_W-1:0]          cfg_dc,
    output logic [DC_W*N_JOINTS-1:0] dc_out,
    output logic                     pwm_en,
    output logic                     busy,
    output logic                     done,
    output logic [PW-1:0]            pose_idx
);

    localparam int unsigned TW = $clog2(TICK_DIV + 1);
    localparam int unsigned DW = $clog2(DWELL_TICKS + 1);

    seq_state_e        state_q, state_d;
    logic [PW-1:0]     pose_q, pose_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              done_q, done_d;
    logic              tick;
    logic              ramp_tick;
    logic              load_en;
    logic [N_JOINTS-1:0] at_target;

    logic [DC_W-1:0] table_q [N_POSES][N_JOINTS];

    // Pose table: writable only while idle, stored already clamped to the legal window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < int'(N_POSES); p++) begin
                for (int j = 0; j < int'(N_JOINTS); j++) begin
                    table_q[p][j] <= DC_W'(DC_MIN);
                end
            end
        end else if (cfg_we && (state_q == StIdle)) begin
            table_q[cfg_pose][cfg_joint] <= clamp_dc(cfg_dc, DC_W'(DC_MIN), DC_W'(DC_MAX));
        end
    end

    assign tick      = (state_q != StIdle) && (tick_cnt_q == TW'(TICK_DIV - 1));
    assign ramp_tick = tick && (state_q == StRamp);
    assign load_en   = (state_q == StLoad);

    always_comb begin
        state_d = state_q;
        pose_d  = pose_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StLoad;
                    pose_d  = '0;
                end
            end
            StLoad: begin
                state_d = StRamp;
            end
            StRamp: begin
                if (&at_target) begin
                    state_d = StDwell;
                    dwell_d = '0;
                end
            end
            StDwell: begin
                if (tick) begin
                    if (dwell_q == DW'(DWELL_TICKS - 1)) begin
                        if (pose_q < last_pose) begin
                            pose_d  = pose_q + 1'b1;
                            state_d = StLoad;
                        end else if (loop) begin
                            pose_d  = '0;
                            state_d = StLoad;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An abort overrides everything, including a completion in the same cycle.
        if (stop && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_d == StLoad) begin
            tick_cnt_d = '0;
        end else if (state_q != StIdle) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            pose_q     <= '0;
            dwell_q    <= '0;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pose_q     <= pose_d;
            dwell_q    <= dwell_d;
            tick_cnt_q <= tick_cnt_d;
            done_q     <= done_d;
        end
    end

    for (genvar j = 0; j < int'(N_JOINTS); j++) begin : g_lane
        servo_joint_ramp #(
            .DC_MIN (DC_MIN),
            .DC_MAX (DC_MAX),
            .STEP   (STEP)
        ) u_ramp (
            .clk       (clk),
            .rst       (rst),
            .target    (table_q[pose_q][j]),
            .tick      (ramp_tick),
            .load_en   (load_en),
            .dc        (dc_out[DC_W*j +: DC_W]),
            .at_target (at_target[j])
        );
    end

    assign pwm_en   = 1'b1;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign pose_idx = pose_q;

endmodule

// File: tb/tb_servo_pose_sequencer.sv
// Scoreboard bench for servo_pose_sequencer: expected output changes are queued with the
// number of cycles since the previous change; a monitor pops one per observed change.
module tb_servo_pose_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, loop, cfg_we;
    logic [2:0]  last_pose, cfg_pose, pose_idx;
    logic [1:0]  cfg_joint;
    logic [10:0] cfg_dc;
    logic [43:0] dc_out;
    logic        pwm_en, busy, done;

    servo_pose_sequencer #(
        .N_JOINTS    (4),
        .N_POSES     (8),
        .DC_MIN      (25),
        .DC_MAX      (125),
        .STEP        (5),
        .TICK_DIV    (4),
        .DWELL_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .last_pose (last_pose),
        .cfg_we    (cfg_we),
        .cfg_pose  (cfg_pose),
        .cfg_joint (cfg_joint),
        .cfg_dc    (cfg_dc),
        .dc_out    (dc_out),
        .pwm_en    (pwm_en),
        .busy      (busy),
        .done      (done),
        .pose_idx  (pose_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] d0, d1, d2, d3;
        logic [2:0]  pidx;
        logic        busy;
        logic        done;
        logic        pwm;
    } rec_t;

    typedef struct {
        rec_t r;
        int   gap;
    } exp_t;

    exp_t exp_q[$];
    rec_t cur, last;
    exp_t ex;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   last_cyc = 0;
    bit   primed = 0;
    bit   mon_en = 0;
    bit   fin_req = 0;

    function automatic rec_t sample_rec();
        rec_t r;
        r.d0   = dc_out[10:0];
        r.d1   = dc_out[21:11];
        r.d2   = dc_out[32:22];
        r.d3   = dc_out[43:33];
        r.pidx = pose_idx;
        r.busy = busy;
        r.done = done;
        r.pwm  = pwm_en;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("dc={%0d,%0d,%0d,%0d} pose=%0d busy=%0b done=%0b pwm_en=%0b",
                         r.d0, r.d1, r.d2, r.d3, r.pidx, r.busy, r.done, r.pwm);
    endfunction

    task automatic push_exp(input int a, input int b, input int c, input int d, input int p,
                            input int bz, input int dn, input int gap);
        exp_t e;
        e.r.d0   = 11'(a);
        e.r.d1   = 11'(b);
        e.r.d2   = 11'(c);
        e.r.d3   = 11'(d);
        e.r.pidx = 3'(p);
        e.r.busy = 1'(bz);
        e.r.done = 1'(dn);
        e.r.pwm  = 1'b1;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: every change of the observed outputs is one scoreboard vector.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = sample_rec();
            cyc_n++;
            if (!primed || (cur != last)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: got %s, required no change", fmt(cur));
                end else begin
                    ex = exp_q.pop_front();
                    if (cur !== ex.r) begin
                        n_err++;
                        $display("FAIL value@cyc%0d: got %s, required %s", cyc_n, fmt(cur),
                                 fmt(ex.r));
                    end else if (primed && (ex.gap >= 0) && (cyc_n - last_cyc != ex.gap)) begin
                        n_err++;
                        $display("FAIL timing@cyc%0d (%s): got gap %0d, required %0d", cyc_n,
                                 fmt(cur), cyc_n - last_cyc, ex.gap);
                    end
                end
                primed   = 1'b1;
                last     = cur;
                last_cyc = cyc_n;
            end
            if (fin_req) begin
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover: got %0d pending, required 0; next %s",
                             exp_q.size(), fmt(exp_q[0].r));
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic timeout(input string what);
        $display("FAIL timeout_%s: got no event, required one within bound (%0d pending)",
                 what, exp_q.size());
        $fatal(1, "bounded wait expired");
    endtask

    task automatic wr(input int p, input int j, input int v);
        cfg_pose  = 3'(p);
        cfg_joint = 2'(j);
        cfg_dc    = 11'(v);
        cfg_we    = 1'b1;
        cyc(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while (busy) begin
            cyc(1);
            i++;
            if (i > lim) timeout("idle");
        end
    endtask

    task automatic wait_dc0(input int v, input int p, input int lim);
        int i = 0;
        while (!((int'(dc_out[10:0]) == v) && (int'(pose_idx) == p))) begin
            cyc(1);
            i++;
            if (i > lim) timeout("dc0");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary, required finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; cfg_we = 1'b0;
        last_pose = '0; cfg_pose = '0; cfg_joint = '0; cfg_dc = '0;

        // Reset state
        push_exp(25, 25, 25, 25, 0, 0, 0, -1);
        cyc(3);
        mon_en = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(2);

        // 1: single pose, joint0 ramps 25->45 in four ticks, dwell, done pulse
        wr(0, 0, 45);
        push_exp(25, 25, 25, 25, 0, 1, 0, -1);
        for (int v = 30; v <= 45; v += 5) push_exp(v, 25, 25, 25, 0, 1, 0, 4);
        push_exp(45, 25, 25, 25, 0, 0, 1, 8);
        push_exp(45, 25, 25, 25, 0, 0, 0, 1);
        pulse_start();
        wait_idle(200);
        cyc(2);

        // 2: clamping on write, short final step, writes ignored while busy
        wr(0, 0, 200);
        wr(0, 1, 10);
        wr(0, 2, 27);
        push_exp(45, 25, 25, 25, 0, 1, 0, -1);
        push_exp(50, 25, 27, 25, 0, 1, 0, 4);
        for (int v = 55; v <= 125; v += 5) push_exp(v, 25, 27, 25, 0, 1, 0, 4);
        push_exp(125, 25, 27, 25, 0, 0, 1, 8);
        push_exp(125, 25, 27, 25, 0, 0, 0, 1);
        pulse_start();
        cyc(6);
        wr(0, 3, 100);
        wait_idle(400);
        cyc(2);
        // Re-run of an already reached pose: one-cycle ramp, normal dwell
        push_exp(125, 25, 27, 25, 0, 1, 0, -1);
        push_exp(125, 25, 27, 25, 0, 0, 1, 8);
        push_exp(125, 25, 27, 25, 0, 0, 0, 1);
        pulse_start();
        wait_idle(200);
        cyc(2);

        // 3/4: two looping poses, then stop mid-ramp at 40 heading for 60
        wr(0, 0, 60);
        wr(1, 0, 30);
        wr(1, 2, 27);
        last_pose = 3'd1;
        loop      = 1'b1;
        push_exp(125, 25, 27, 25, 0, 1, 0, -1);
        for (int v = 120; v >= 60; v -= 5) push_exp(v, 25, 27, 25, 0, 1, 0, 4);
        push_exp(60, 25, 27, 25, 1, 1, 0, 8);
        for (int v = 55; v >= 30; v -= 5) push_exp(v, 25, 27, 25, 1, 1, 0, 4);
        push_exp(30, 25, 27, 25, 0, 1, 0, 8);
        push_exp(35, 25, 27, 25, 0, 1, 0, 4);
        push_exp(40, 25, 27, 25, 0, 1, 0, 4);
        push_exp(40, 25, 27, 25, 0, 0, 0, -1);
        pulse_start();
        wait_dc0(40, 0, 400);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(10);

        // 5: start+stop together from idle does nothing
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        cyc(6);

        // 5: start during ramp is ignored; 6: reset during dwell
        loop = 1'b0;
        push_exp(40, 25, 27, 25, 0, 1, 0, -1);
        for (int v = 45; v <= 60; v += 5) push_exp(v, 25, 27, 25, 0, 1, 0, 4);
        push_exp(60, 25, 27, 25, 1, 1, 0, 8);
        for (int v = 55; v >= 30; v -= 5) push_exp(v, 25, 27, 25, 1, 1, 0, 4);
        push_exp(25, 25, 25, 25, 0, 0, 0, -1);
        pulse_start();
        wait_dc0(50, 1, 400);
        pulse_start();
        wait_dc0(30, 1, 200);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);

        // Table back at DC_MIN: pose 0 equals current positions
        last_pose = 3'd0;
        push_exp(25, 25, 25, 25, 0, 1, 0, -1);
        push_exp(25, 25, 25, 25, 0, 0, 1, 8);
        push_exp(25, 25, 25, 25, 0, 0, 0, 1);
        pulse_start();
        wait_idle(200);
        cyc(2);

        fin_req = 1'b1;
        cyc(5);
        timeout("summary");
    end

endmodule
